// File: rtl/mult_seq_32b.sv
// Sequential unsigned 32x32->64 shift-add multiplier with valid/ready on both sides.
// One shared ripple adder performs a single partial-product add per cycle.

module fulladder_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[32];
endmodule

module mult_seq_32b #(
  parameter int EARLY_EXIT = 1,
  parameter int ITER       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mcand;
  logic [4:0]  cnt;

  logic [31:0] addend;
  logic [31:0] sum;
  logic        carry;
  logic        zero_op;

  // lo[0] is the current multiplier bit; lo shifts it out as product bits shift in.
  assign addend  = lo[0] ? mcand : 32'd0;
  assign zero_op = (EARLY_EXIT != 0) && ((a == 32'd0) || (b == 32'd0));
  assign product = {hi, lo};

  fulladder_32b u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi        <= 32'd0;
      lo        <= 32'd0;
      mcand     <= 32'd0;
      cnt       <= 5'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a;
            hi       <= 32'd0;
            cnt      <= 5'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (zero_op) begin
              lo        <= 32'd0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              lo    <= b;
              state <= CALC;
            end
          end
        end
        CALC: begin
          // Carry lands in hi[31], so no step can overflow the 64-bit result.
          hi  <= {carry, sum[31:1]};
          lo  <= {sum[0], lo[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq_32b.sv
// Bench for mult_seq_32b: randomized operands checked by a queue-based scoreboard
// against plain 64-bit multiplication, plus directed reset and backpressure cases.

module tb_mult_seq_32b;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] product;

  logic        in_valid0, in_ready0, out_valid0, busy0;
  logic [31:0] a0, b0;
  logic [63:0] product0;

  localparam int EE = 1;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        prev_ov = 1'b0;
  logic        prev_or = 1'b0;
  logic [63:0] last = 64'd0;
  logic        rand_or = 1'b0;
  logic        or_fixed = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_seq_32b #(.EARLY_EXIT(EE), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mult_seq_32b #(.EARLY_EXIT(0), .ITER(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(1'b1),
    .product(product0), .busy(busy0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each new result against the scoreboard and owns out_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      out_ready = 1'b1;
      prev_or   = 1'b1;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.prod);
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          last = e.prod;
        end
      end else if (out_valid) begin
        check("hold_product_stable", product, last);
        check("hold_in_ready_low", 64'(in_ready), 64'd0);
        check("hold_busy_high", 64'(busy), 64'd1);
      end
      if (prev_ov && prev_or) begin
        check("consume_out_valid_low", 64'(out_valid), 64'd0);
        check("consume_in_ready_high", 64'(in_ready), 64'd1);
        check("product_kept_after_consume", product, last);
      end
      if (prev_ov && !prev_or)
        check("out_valid_held_without_ready", 64'(out_valid), 64'd1);
      prev_ov   = out_valid;
      out_ready = rand_or ? ($urandom_range(0, 3) != 0) : or_fixed;
      prev_or   = out_ready;
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    e.prod = {32'd0, x} * {32'd0, y};
    e.lat  = (EE != 0 && (x == 0 || y == 0)) ? 0 : 32;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    if (e.lat != 0) check("in_ready_low_in_calc", 64'(in_ready), 64'd0);
  endtask

  task automatic pulse_ignored(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (in_ready) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic async_reset_check();
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, start;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Same zero operand without early exit takes the full iteration count.
    @(negedge clk);
    a0 = 32'd0; b0 = 32'h1234_5678; in_valid0 = 1'b1;
    start = cyc + 1;
    @(negedge clk);
    in_valid0 = 1'b0;
    check("ee0_busy", 64'(busy0), 64'd1);
    n = 0;
    while (!out_valid0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ee0_latency", 64'(cyc - start), 64'd32);
    check("ee0_product", product0, 64'd0);

    issue(32'd3, 32'd5);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'd2);
    issue(32'd0, 32'h1234_5678);
    issue(32'hDEAD_BEEF, 32'd0);

    // Backpressure: stall HOLD for 10 cycles while junk operands are offered.
    @(posedge clk); #1 or_fixed = 1'b0;
    issue($urandom, $urandom | 32'd1);
    pulse_ignored(5);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 64'(out_valid), 64'd1);
    pulse_ignored(10);
    #1 or_fixed = 1'b1;

    // Reset in the middle of CALC discards the operation.
    issue(32'd7, 32'd9);
    repeat (11) @(posedge clk);
    async_reset_check();
    issue(32'd6, 32'd7);

    @(posedge clk); #1 rand_or = 1'b1;
    for (int i = 0; i < 30; i++)
      issue(($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
            ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom);

    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
